pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Match sequencer that sits beside the PONG game core and drives its PAUSE and RESET inputs.
- Steps the game through attract, clear, serve countdown, play, user hold, point freeze and game-over phases.
- Watches the core's Score_1/Score_2/WIN1/WIN2 outputs; takes START and PAUSE_BTN from board buttons.

Parameters:
- TICK_DIV, 312500: CLK cycles per game tick (matches core game speed); legal 2..2^27-1
- SERVE_TICKS, 120: ticks the ball is held before a serve; legal 1..1023
- POINT_TICKS, 60: ticks the game freezes after a point; legal 1..1023

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous active-low reset
- START  in  1  raw start button, active-high, asynchronous to CLK
- PAUSE_BTN  in  1  raw pause button, active-high, asynchronous to CLK
- Score_1  in  5  player 1 score from core
- Score_2  in  5  player 2 score from core
- WIN1  in  1  player 1 win flag from core
- WIN2  in  1  player 2 win flag from core
- core_pause  out  1  to core PAUSE; 1 = core frozen
- core_reset_n  out  1  to core RESET; active-low
- state  out  3  current state encoding
- timer  out  10  remaining ticks in SERVE/POINT, else 0
- point_flag  out  2  in POINT: bit0 = player 1 scored, bit1 = player 2 scored; else 0
- winner  out  2  in OVER: {WIN2,WIN1} latched on entry; else 0

Behaviour:
- All outputs registered. Reset values: state=ATTRACT, core_pause=1, core_reset_n=1, timer=0, point_flag=0, winner=0. Tick counter, previous-score registers and button synchronisers clear to 0.
- Buttons: each passes through a 2-flop synchroniser, then a rising-edge detector giving a 1-cycle pulse (start_p, pause_p). Input-to-pulse latency is 3 cycles. A held button yields a single pulse.
- Tick: a free-running counter counts 0..TICK_DIV-1. tick=1 on the cycle it wraps. The counter is never cleared by state changes, so a load of N expires after N ticks, the first of which may be partial.
- Score change: scored = (Score_1 != prev1) | (Score_2 != prev2). prev1/prev2 load the inputs every cycle in every state. scored is acted on only in PLAY.
- States (encoding 0..6):
  - ATTRACT: core_pause=1. start_p -> CLEAR.
  - CLEAR: core_pause=0, core_reset_n=0 for exactly 2 cycles. The core only honours reset while unpaused. Then -> SERVE with timer=SERVE_TICKS and core_reset_n=1.
  - SERVE: core_pause=1; timer decrements on tick; tick with timer==1 -> PLAY, timer=0.
  - PLAY: core_pause=0. Priority order:
    - WIN1|WIN2 -> OVER, latch winner.
    - else scored -> POINT, point_flag={Score_2!=prev2, Score_1!=prev1}, timer=POINT_TICKS.
    - else pause_p -> HOLD.
    - start_p is ignored.
  - HOLD: core_pause=1; pause_p -> PLAY; start_p -> CLEAR (abandon match).
  - POINT: core_pause=1; WIN1|WIN2 -> OVER (latch winner, clear point_flag). Else timer decrements on tick; tick with timer==1 -> SERVE, timer=SERVE_TICKS, point_flag=0.
  - OVER: core_pause=1; start_p -> CLEAR, winner=0.
- Simultaneous events: within a state, the priority order is as listed above. A pulse not consumed in its cycle is lost.
- Width rules: timer is 10-bit unsigned and never underflows; the decrement only occurs while timer>0. Tick counter is 27 bits.
- Reset mid-operation: asynchronous return to reset values in any state. core_reset_n is not asserted by RESET; the core is only cleared via CLEAR.

Decomposition:
- pong_pkg holds: state encodings ATTRACT=0, CLEAR=1, SERVE=2, PLAY=3, HOLD=4, POINT=5, OVER=6; CLEAR_CYCLES=2; TIMER_W=10; TICK_W=27.
- One sub-module, pong_btn_edge (2-flop sync + rising-edge pulse, async active-low reset), instantiated for START and PAUSE_BTN.

Test Plan (TICK_DIV=4, SERVE_TICKS=3, POINT_TICKS=2):
- Release RESET, hold START high 50 cycles -> exactly one CLEAR: core_reset_n low exactly 2 cycles, then SERVE with timer=3; PLAY within 9..12 cycles of SERVE entry; core_pause falls to 0 on PLAY entry.
- In PLAY, step Score_1 0->1 -> next cycle state=POINT, point_flag=2'b01, core_pause=1; after 2 ticks state=SERVE, timer=3, point_flag=0.
- In PLAY, same cycle Score_2 1->2, WIN2=1 and pause_p -> state=OVER, winner=2'b10, point_flag=0; a later START pulse -> CLEAR, winner=0.
- In PLAY, pulse PAUSE_BTN -> HOLD with core_pause=1 and timer frozen; pulse again -> PLAY; pulse START while in HOLD -> CLEAR.
- Assert RESET low mid-POINT with timer=1 -> immediately state=ATTRACT, core_pause=1, timer=0, point_flag=0, core_reset_n=1.
- Scores held constant with no buttons for 1000 cycles in ATTRACT -> no state change; Score_1 change in SERVE/HOLD -> ignored; prev1 tracks it, so there is no spurious POINT on entering PLAY.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings and widths for the PONG match sequencer.
package pong_pkg;

   typedef enum logic [2:0] {
      ATTRACT = 3'd0,
      CLEAR   = 3'd1,
      SERVE   = 3'd2,
      PLAY    = 3'd3,
      HOLD    = 3'd4,
      POINT   = 3'd5,
      OVER    = 3'd6
   } state_e;

   localparam int CLEAR_CYCLES = 2;
   localparam int TIMER_W      = 10;
   localparam int TICK_W       = 27;

endpackage

// File: rtl/pong_btn_edge.sv
// Raw button to single-cycle pulse: 2-flop synchroniser, delay flop and
// a registered rising-edge detector (input-to-pulse latency of 3 cycles).
module pong_btn_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_pulse;

   // Synchronise the asynchronous button and register its rising edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_pulse <= r_sync2 & ~r_sync3;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer driving the PONG core's PAUSE and RESET inputs.
// Walks attract, clear, serve countdown, play, hold, point freeze and
// game-over phases from the core's score/win flags and two board buttons.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = 312500,
   parameter int SERVE_TICKS = 120,
   parameter int POINT_TICKS = 60
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         START,
   input  logic         PAUSE_BTN,
   input  logic [4:0]   Score_1,
   input  logic [4:0]   Score_2,
   input  logic         WIN1,
   input  logic         WIN2,
   output logic         core_pause,
   output logic         core_reset_n,
   output logic [2:0]   state,
   output logic [9:0]   timer,
   output logic [1:0]   point_flag,
   output logic [1:0]   winner
);

   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TIMER_W-1:0] SERVE_LD  = TIMER_W'(SERVE_TICKS);
   localparam logic [TIMER_W-1:0] POINT_LD  = TIMER_W'(POINT_TICKS);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
   localparam logic [1:0]         CLR_LAST  = 2'(CLEAR_CYCLES - 1);

   logic               w_start_p;
   logic               w_pause_p;
   logic               w_tick;
   logic               w_scored;
   logic               w_win;

   logic [TICK_W-1:0]  r_tick_cnt;
   logic [4:0]         r_prev1;
   logic [4:0]         r_prev2;
   state_e             r_state;
   logic               r_core_pause;
   logic               r_core_reset_n;
   logic [TIMER_W-1:0] r_timer;
   logic [1:0]         r_point_flag;
   logic [1:0]         r_winner;
   logic [1:0]         r_clr_cnt;

   pong_btn_edge u_start_edge (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_btn   (START),
      .o_pulse (w_start_p)
   );

   pong_btn_edge u_pause_edge (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_btn   (PAUSE_BTN),
      .o_pulse (w_pause_p)
   );

   assign w_tick   = (r_tick_cnt == TICK_LAST);
   assign w_scored = (Score_1 != r_prev1) | (Score_2 != r_prev2);
   assign w_win    = WIN1 | WIN2;

   // Free-running game tick divider, independent of the match phase
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // Previous scores track the core in every phase so no stale change leaks into PLAY
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_prev1 <= '0;
         r_prev2 <= '0;
      end else begin
         r_prev1 <= Score_1;
         r_prev2 <= Score_2;
      end
   end

   // Match phase sequencer with registered core controls and status
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state        <= ATTRACT;
         r_core_pause   <= 1'b1;
         r_core_reset_n <= 1'b1;
         r_timer        <= '0;
         r_point_flag   <= '0;
         r_winner       <= '0;
         r_clr_cnt      <= '0;
      end else begin
         case (r_state)
            ATTRACT: begin
               if (w_start_p) begin
                  r_state        <= CLEAR;
                  r_core_pause   <= 1'b0;
                  r_core_reset_n <= 1'b0;
                  r_clr_cnt      <= '0;
               end
            end
            CLEAR: begin
               // core only honours its reset while unpaused, so pause stays low here
               if (r_clr_cnt == CLR_LAST) begin
                  r_state        <= SERVE;
                  r_core_pause   <= 1'b1;
                  r_core_reset_n <= 1'b1;
                  r_timer        <= SERVE_LD;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            SERVE: begin
               if (w_tick) begin
                  if (r_timer == TIMER_ONE) begin
                     r_state      <= PLAY;
                     r_core_pause <= 1'b0;
                     r_timer      <= '0;
                  end else if (r_timer != '0) begin
                     r_timer <= r_timer - 1'b1;
                  end
               end
            end
            PLAY: begin
               if (w_win) begin
                  r_state      <= OVER;
                  r_core_pause <= 1'b1;
                  r_winner     <= {WIN2, WIN1};
               end else if (w_scored) begin
                  r_state      <= POINT;
                  r_core_pause <= 1'b1;
                  r_point_flag <= {Score_2 != r_prev2, Score_1 != r_prev1};
                  r_timer      <= POINT_LD;
               end else if (w_pause_p) begin
                  r_state      <= HOLD;
                  r_core_pause <= 1'b1;
               end
            end
            HOLD: begin
               if (w_pause_p) begin
                  r_state      <= PLAY;
                  r_core_pause <= 1'b0;
               end else if (w_start_p) begin
                  r_state        <= CLEAR;
                  r_core_pause   <= 1'b0;
                  r_core_reset_n <= 1'b0;
                  r_clr_cnt      <= '0;
               end
            end
            POINT: begin
               if (w_win) begin
                  r_state      <= OVER;
                  r_winner     <= {WIN2, WIN1};
                  r_point_flag <= '0;
                  r_timer      <= '0;
               end else if (w_tick) begin
                  if (r_timer == TIMER_ONE) begin
                     r_state      <= SERVE;
                     r_timer      <= SERVE_LD;
                     r_point_flag <= '0;
                  end else if (r_timer != '0) begin
                     r_timer <= r_timer - 1'b1;
                  end
               end
            end
            OVER: begin
               if (w_start_p) begin
                  r_state        <= CLEAR;
                  r_core_pause   <= 1'b0;
                  r_core_reset_n <= 1'b0;
                  r_clr_cnt      <= '0;
                  r_winner       <= '0;
               end
            end
            default: begin
               r_state        <= ATTRACT;
               r_core_pause   <= 1'b1;
               r_core_reset_n <= 1'b1;
               r_timer        <= '0;
               r_point_flag   <= '0;
               r_winner       <= '0;
            end
         endcase
      end
   end

   assign core_pause   = r_core_pause;
   assign core_reset_n = r_core_reset_n;
   assign state        = r_state;
   assign timer        = r_timer;
   assign point_flag   = r_point_flag;
   assign winner       = r_winner;

endmodule
